// File: rtl/aurora_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one Aurora TX AXI-Stream lane among NUM_REQ requesters.
// Whole frames are granted atomically; a frame cut by channel loss is sunk and counted as dropped.
module aurora_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   USER_CLK,
  input  logic                   RESET,
  input  logic                   CHANNEL_UP,
  input  logic [32*NUM_REQ-1:0]  s_tdata,
  input  logic [4*NUM_REQ-1:0]   s_tkeep,
  input  logic [NUM_REQ-1:0]     s_tvalid,
  input  logic [NUM_REQ-1:0]     s_tlast,
  output logic [NUM_REQ-1:0]     s_tready,
  output logic [0:31]            m_tdata,
  output logic [0:3]             m_tkeep,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     frame_q, frame_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic [IDX_W-1:0]     pick;
  logic                 beat;

  // First valid requester strictly after the previous owner, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] last,
                                                input logic [NUM_REQ-1:0] vld);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               cand;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      if (!found && vld[cand]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(last_q, s_tvalid);

  assign m_tdata = s_tdata[32*owner_q +: 32];
  assign m_tkeep = s_tkeep[4*owner_q +: 4];
  assign m_tlast = s_tlast[owner_q];

  // Handshake outputs are forced low while RESET is high, even before the state register clears.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    if (!RESET) begin
      case (state_q)
        XFER: begin
          m_tvalid          = s_tvalid[owner_q] & CHANNEL_UP;
          s_tready[owner_q] = m_tready & CHANNEL_UP;
        end
        FLUSH:   s_tready[owner_q] = 1'b1;
        default: ;
      endcase
    end
  end

  assign beat = m_tvalid & m_tready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (CHANNEL_UP && (|s_tvalid)) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = XFER;
        end
      end
      XFER: begin
        if (!CHANNEL_UP) begin
          state_d = FLUSH;
        end else if (beat && s_tlast[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
          if (frame_q != '1) frame_d = frame_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (s_tvalid[owner_q] && s_tlast[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  assign grant     = grant_q;
  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;

endmodule
